muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply/divide unit for a MIPS-style HI/LO pipeline.
// Fixed 36-cycle latency for every operation: shift-add multiply and restoring divide.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] opd_q, opd_d;   // multiplicand or divisor magnitude
  logic [DW-1:0]    acc_q, acc_d;   // {hi, lo} working register
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div, is_signed;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_next;
  logic [WIDTH:0]   div_trial;
  logic [DW-1:0]    div_next;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot, rem;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  assign neg_a = is_signed & a_q[WIDTH-1];
  assign neg_b = is_signed & b_q[WIDTH-1];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;

  // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
  assign mul_addend = acc_q[0] ? opd_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift left, try subtracting divisor, keep result only on no borrow.
  assign div_trial = acc_q[DW-1:WIDTH-1] - {1'b0, opd_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[DW-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[DW-1:WIDTH];

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
        end
      end
      S_PREP: begin
        state_d  = S_RUN;
        cnt_d    = '0;
        neg_lo_d = neg_a ^ neg_b;
        neg_hi_d = neg_a;
        if (is_div) begin
          acc_d = {{WIDTH{1'b0}}, mag_a};
          opd_d = mag_b;
          dz_d  = (b_q == '0);
        end else begin
          acc_d = {{WIDTH{1'b0}}, mag_b};
          opd_d = mag_a;
          dz_d  = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (!is_div) begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          // Divide by zero reports all-ones quotient and the untouched dividend as remainder.
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = neg_hi_q ? -rem : rem;
          lo_d = neg_lo_q ? -quot : quot;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign hilo_we  = done;
  assign div_zero = done & dz_q;
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latency, busy/done timing,
// start-while-busy rejection and mid-operation reset.
module tb_muldiv_seq;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, hilo_we, div_zero;
  logic [31:0] hi_wdata, lo_wdata;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int viol = 0;
  bit mon_en = 1'b0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts done pulses and flags any write enable or div_zero outside a done cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) done_cnt++;
      if (hilo_we !== done) viol++;
      if (div_zero === 1'b1 && done !== 1'b1) viol++;
    end
  end

  // Called at a negedge (cycle 0); returns at the cycle-1 negedge with operands scrambled.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    check("busy_c1", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp, input logic exp_dz);
    int lat;
    start_op(o, x, y);
    wait_done(1, lat);
    check({tag, "_lat"}, 64'(lat), 64'd35);
    check({tag, "_res"}, {hi_wdata, lo_wdata}, exp);
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    check({tag, "_we"}, {62'd0, busy, hilo_we}, 64'd3);
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_hold"}, {hi_wdata, lo_wdata}, exp);
  endtask

  initial begin
    int lat;
    int dc0;

    // Reset with start held high: the start on reset edges must be ignored.
    rst   = 1'b0;
    start = 1'b1;
    op    = MULT;
    a     = 32'd3;
    b     = 32'd4;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    start  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_ctrl", {60'd0, busy, done, hilo_we, div_zero}, 64'd0);
    check("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);

    run_vec("mult_neg",   MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0);
    run_vec("multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    run_vec("mult_min",   MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    run_vec("div_neg",    DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_vec("div_negb",   DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    run_vec("divu_zero",  DIVU,  32'd100,      32'd0,        64'h00000064_FFFFFFFF, 1'b1);
    run_vec("div_zero_s", DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1'b1);
    run_vec("div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_vec("divu_plain", DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 1'b0);

    // Start pulsed mid-operation must be dropped; restart right after DONE is accepted.
    dc0 = done_cnt;
    start_op(DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    a     = 32'd50;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat);
    check("busy_start_lat", 64'(lat), 64'd35);
    check("busy_start_res", {hi_wdata, lo_wdata}, 64'h00000001_0000014D);
    @(negedge clk);
    check("busy_start_pulses", 64'(done_cnt - dc0), 64'd1);
    check("c36_idle", 64'(busy), 64'd0);
    start_op(DIVU, 32'd50, 32'd5);
    wait_done(37, lat);
    check("restart_c71", 64'(lat), 64'd71);
    check("restart_res", {hi_wdata, lo_wdata}, 64'h00000000_0000000A);
    @(negedge clk);
    check("restart_pulses", 64'(done_cnt - dc0), 64'd2);

    // Reset in the middle of RUN aborts the multiply without any write.
    dc0 = done_cnt;
    start_op(MULT, 32'd3, 32'd4);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_ctrl", {60'd0, busy, done, hilo_we, div_zero}, 64'd0);
    check("abort_hilo", {hi_wdata, lo_wdata}, 64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    run_vec("post_rst", MULT, 32'd6, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFD6, 1'b0);

    check("we_outside_done", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
